// File: rtl/vga_pixel_fetch.sv
// VRAM-to-pixel fetch engine: two-word prefetch buffer, MSB-first unpack.
// Define VGA_PIXEL_FETCH_DOUBLE_SCAN_EN to fetch each source line twice.
module vga_pixel_fetch #(
  parameter int WORD_W   = 16,
  parameter int BPP      = 4,
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pixel_req,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  input  logic [WORD_W-1:0] vram_data,
  output logic [BPP-1:0]    pixel_data,
  output logic              pixel_valid,
  output logic              underrun
);
  localparam int PPW = WORD_W / BPP;
  localparam int WPL = H_ACTIVE / PPW;
  localparam int PW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int CW  = $clog2(WPL + 1);
  localparam int LW  = $clog2(V_ACTIVE + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LW-1:0]       line_q, line_d;
  logic [LW-1:0]       cur_line, src_line;
  logic                rd_q, rd_d;
  logic [CW-1:0]       issued_q, issued_d;
  logic [CW-1:0]       popped_q, popped_d;
  logic [WORD_W-1:0]   buf0_q, buf0_d;
  logic [WORD_W-1:0]   buf1_q, buf1_d;
  logic [WORD_W-1:0]   head_sh;
  logic [1:0]          occ_q, occ_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [READ_LAT-1:0] pipe_q, pipe_d;
  logic [BPP-1:0]      pix_q, pix_d;
  logic                pv_q, pv_d;
  logic                und_q, und_d;
  logic                pop, arrive;
  logic [3:0]          pend;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    addr_d   = addr_q;
    line_d   = line_q;
    issued_d = issued_q;
    popped_d = popped_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    occ_d    = occ_q;
    ptr_d    = ptr_q;
    pix_d    = '0;
    pv_d     = 1'b0;
    und_d    = und_q;
    pop      = 1'b0;
    arrive   = pipe_q[READ_LAT-1];
    head_sh  = buf0_q << (ptr_q * BPP);
    cur_line = frame_start ? '0 : line_q;
`ifdef VGA_PIXEL_FETCH_DOUBLE_SCAN_EN
    src_line = cur_line >> 1;
`else
    src_line = cur_line;
`endif

    if (pixel_req && state_q == FETCH) begin
      if (occ_q != 2'd0) begin
        pix_d = head_sh[WORD_W-1 -: BPP];
        pv_d  = 1'b1;
        if (ptr_q == PW'(PPW - 1)) begin
          ptr_d = '0;
          pop   = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end else begin
        und_d = 1'b1;
      end
    end

    if (rd_q) begin
      addr_d   = addr_q + 1'b1;
      issued_d = issued_q + 1'b1;
    end

    pipe_d    = '0;
    pipe_d[0] = rd_q;
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    // pop first so a same-cycle arrival lands in the freed slot
    if (pop) begin
      buf0_d   = buf1_q;
      occ_d    = occ_q - 2'd1;
      popped_d = popped_q + 1'b1;
    end
    if (arrive) begin
      if (occ_d == 2'd0) buf0_d = vram_data;
      else               buf1_d = vram_data;
      occ_d = occ_d + 2'd1;
    end

    if (state_q == FETCH && popped_d == CW'(WPL)) state_d = DONE;

    if (frame_start) begin
      base_d  = fb_base;
      line_d  = '0;
      und_d   = 1'b0;
      state_d = IDLE;
    end
    if (frame_start || line_start) begin
      occ_d    = '0;
      ptr_d    = '0;
      pipe_d   = '0;
      issued_d = '0;
      popped_d = '0;
    end
    if (line_start) begin
      addr_d  = base_d + ADDR_W'(int'(src_line) * WPL);
      state_d = (cur_line >= LW'(V_ACTIVE)) ? DONE : FETCH;
      if (cur_line < LW'(V_ACTIVE)) line_d = cur_line + 1'b1;
      else                          line_d = cur_line;
    end

    pend = {2'b00, occ_d};
    for (int i = 0; i < READ_LAT; i++) begin
      pend = pend + {3'b000, pipe_d[i]};
    end
    rd_d = (state_d == FETCH) && (pend < 4'd2) &&
           (issued_d < CW'(WPL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      line_q   <= '0;
      rd_q     <= 1'b0;
      issued_q <= '0;
      popped_q <= '0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      occ_q    <= '0;
      ptr_q    <= '0;
      pipe_q   <= '0;
      pix_q    <= '0;
      pv_q     <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      line_q   <= line_d;
      rd_q     <= rd_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      occ_q    <= occ_d;
      ptr_q    <= ptr_d;
      pipe_q   <= pipe_d;
      pix_q    <= pix_d;
      pv_q     <= pv_d;
      und_q    <= und_d;
    end
  end

  assign vram_addr   = addr_q;
  assign vram_rd     = rd_q;
  assign pixel_data  = pix_q;
  assign pixel_valid = pv_q;
  assign underrun    = und_q;

endmodule
